dec_onehot_seq: RTL

//  Registered, parametrised N-to-2^N one-hot decoder with a valid/ready request handshake.

---
 rtl/dec_onehot_seq_if.sv | 33 +++
 rtl/dec_onehot_seq.sv | 120 ++++++++++++
 2 files changed

// File: rtl/dec_onehot_seq_if.sv
// Request/strobe bundle for dec_onehot_seq.
// DEC_SCAN_EN adds the scan_start request line.
interface dec_onehot_seq_if #(
  parameter int N_SEL = 3
);
  logic                  sel_valid;
  logic                  sel_ready;
  logic [N_SEL-1:0]      sel;
  logic                  abort;
`ifdef DEC_SCAN_EN
  logic                  scan_start;
`endif
  logic [(2**N_SEL)-1:0] d;
  logic                  busy;
  logic                  done;
  logic [N_SEL-1:0]      cur_idx;

  modport master (
    output sel_valid, sel, abort,
`ifdef DEC_SCAN_EN
    output scan_start,
`endif
    input  sel_ready, d, busy, done, cur_idx
  );

  modport slave (
    input  sel_valid, sel, abort,
`ifdef DEC_SCAN_EN
    input  scan_start,
`endif
    output sel_ready, d, busy, done, cur_idx
  );
endinterface

// File: rtl/dec_onehot_seq.sv
// Registered N-to-2^N one-hot strobe generator: each accepted select is held HOLD_CYCLES clocks.
// Defining DEC_SCAN_EN adds an auto-scan mode that walks every output in turn.
module dec_onehot_seq #(
  parameter int N_SEL       = 3,
  parameter int HOLD_CYCLES = 1
) (
  input logic             clk,
  input logic             rst_n,
  dec_onehot_seq_if.slave bus
);
  localparam int DW = 2**N_SEL;
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0]    CNT_LAST = CW'(1);
  localparam logic [DW-1:0]    ONE      = DW'(1);
  localparam logic [N_SEL-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1
`ifdef DEC_SCAN_EN
    , SCAN = 2'd2
`endif
  } state_t;

  state_t           state, state_n;
  logic [DW-1:0]    d_q, d_n;
  logic [N_SEL-1:0] idx_q, idx_n;
  logic [CW-1:0]    cnt_q, cnt_n;
  logic             last_cycle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      d_q   <= '0;
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_n;
      d_q   <= d_n;
      idx_q <= idx_n;
      cnt_q <= cnt_n;
    end
  end

  // D is the register itself, so the strobes cannot glitch between edges.
  always_comb begin
    state_n = state;
    d_n     = d_q;
    idx_n   = idx_q;
    cnt_n   = cnt_q;
    case (state)
      IDLE: begin
        if (bus.sel_valid) begin
          state_n = HOLD;
          d_n     = ONE << bus.sel;
          idx_n   = bus.sel;
          cnt_n   = CNT_LOAD;
        end
`ifdef DEC_SCAN_EN
        else if (bus.scan_start) begin
          state_n = SCAN;
          d_n     = ONE;
          idx_n   = '0;
          cnt_n   = CNT_LOAD;
        end
`endif
      end
      HOLD: begin
        if (bus.abort || cnt_q == CNT_LAST) begin
          state_n = IDLE;
          d_n     = '0;
          idx_n   = '0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q - CNT_LAST;
        end
      end
`ifdef DEC_SCAN_EN
      SCAN: begin
        if (bus.abort || (cnt_q == CNT_LAST && idx_q == IDX_LAST)) begin
          state_n = IDLE;
          d_n     = '0;
          idx_n   = '0;
          cnt_n   = '0;
        end else if (cnt_q == CNT_LAST) begin
          d_n   = d_q << 1;
          idx_n = idx_q + 1'b1;
          cnt_n = CNT_LOAD;
        end else begin
          cnt_n = cnt_q - CNT_LAST;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        d_n     = '0;
        idx_n   = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // DONE comes from registered state only; an abort cannot retract it within the same cycle.
  always_comb begin
    last_cycle = 1'b0;
    if (state == HOLD && cnt_q == CNT_LAST)
      last_cycle = 1'b1;
`ifdef DEC_SCAN_EN
    if (state == SCAN && cnt_q == CNT_LAST && idx_q == IDX_LAST)
      last_cycle = 1'b1;
`endif
  end

  assign bus.d         = d_q;
  assign bus.cur_idx   = idx_q;
  assign bus.busy      = (state != IDLE);
  assign bus.sel_ready = (state == IDLE);
  assign bus.done      = last_cycle;
endmodule
